escaner_pads: RTL and testbench

ESCANER_PADS -- requirements
Module: escaner_pads

---
 rtl/escaner_pads.sv | 131 +++++++++++++
 tb/tb_escaner_pads.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/escaner_pads.sv
// escaner_pads: 4x4 drum-pad matrix scanner with frame-based debounce.
// One row strobe is driven low at a time for DWELL cycles; the columns are
// sampled in the last dwell cycle of each row.  After the row-3 sample the
// assembled 16-bit frame is evaluated in the following cycle.  A frame has
// to repeat DEBOUNCE_SCANS times before it replaces the accepted pad state.
// On acceptance, valido pulses with the lowest newly pressed pad.
// Optional build macro: ESCANER_PADS_SYNC_EN adds a two-flop column
// synchronizer ahead of the sampling point.
module escaner_pads #(
  parameter int DWELL          = 400,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  filas,
  input  logic [3:0]  columnas,
  output logic [15:0] teclas,
  output logic [3:0]  codigo,
  output logic        valido
);

  localparam logic [10:0] LAST_CNT  = 11'(DWELL - 1);
  localparam logic [3:0]  MATCH_MAX = 4'(DEBOUNCE_SCANS);

  logic [10:0] cnt;
  logic [1:0]  row;
  logic [3:0]  col_s;
  logic [11:0] raw_acc;
  logic [15:0] frame_q;
  logic        eval_q;
  logic [15:0] prev_q;
  logic [3:0]  match_q;

  logic        sample_en;
  logic [3:0]  match_next;
  logic        accept;
  logic [15:0] new_pads;
  logic [3:0]  low_idx;
  logic        strobe;

`ifdef ESCANER_PADS_SYNC_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  // Two-flop synchronizer on the asynchronous column returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= columnas;
      sync2 <= sync1;
    end
  end

  assign col_s = sync2;
`else
  assign col_s = columnas;
`endif

  // Row index r pulls filas[3-r] low: 0111, 1011, 1101, 1110.
  assign filas     = ~(4'b1000 >> row);
  assign sample_en = (cnt == LAST_CNT);

  // Dwell counter and row sequencer; never stalls for evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      row <= '0;
    end else if (sample_en) begin
      cnt <= '0;
      row <= row + 2'd1;
    end else begin
      cnt <= cnt + 11'd1;
    end
  end

  // Column capture per row; the row-3 sample completes the raw frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_acc <= '0;
      frame_q <= '0;
      eval_q  <= 1'b0;
    end else begin
      eval_q <= sample_en && (row == 2'd3);
      if (sample_en) begin
        case (row)
          2'd0:    raw_acc[3:0]  <= ~col_s;
          2'd1:    raw_acc[7:4]  <= ~col_s;
          2'd2:    raw_acc[11:8] <= ~col_s;
          default: frame_q       <= {~col_s, raw_acc};
        endcase
      end
    end
  end

  // Debounce decision and lowest-index new pad for the evaluation cycle.
  always_comb begin
    match_next = 4'd1;
    if (frame_q == prev_q) begin
      match_next = (match_q >= MATCH_MAX) ? MATCH_MAX : match_q + 4'd1;
    end
    new_pads = frame_q & ~teclas;
    low_idx  = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (new_pads[k]) low_idx = 4'(k);
    end
    accept = eval_q && (match_next == MATCH_MAX) && (frame_q != teclas);
    strobe = accept && (|new_pads);
  end

  // Debounce state, accepted pad state and the report strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      match_q <= '0;
      teclas  <= '0;
      codigo  <= '0;
      valido  <= 1'b0;
    end else begin
      valido <= strobe;
      if (eval_q) begin
        prev_q  <= frame_q;
        match_q <= match_next;
      end
      if (accept) teclas <= frame_q;
      if (strobe) codigo <= low_idx;
    end
  end

endmodule

// File: tb/tb_escaner_pads.sv
// Directed bench for escaner_pads with DWELL=4, DEBOUNCE_SCANS=2.
// A pad-matrix model drives columnas from the held-pad set and filas.
// Pad changes are applied in the second half of cycle 1 of each frame so
// that both the direct and the synchronized build see whole frames.
module tb_escaner_pads;

  localparam int DW    = 4;
  localparam int DEB   = 2;
  localparam int FRAME = 4 * DW;

  logic        clk;
  logic        rst_n;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [15:0] teclas;
  logic [3:0]  codigo;
  logic        valido;

  logic [15:0] pads;
  int          n_checks;
  int          n_fail;
  logic [3:0]  exp_q[$];
  logic        prev_valido;
  logic [3:0]  last_code;

  typedef struct {
    logic [15:0] pads;
    int          frames;
    logic [15:0] exp_teclas;
    bit          exp_strobe;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[11];

  escaner_pads #(.DWELL(DW), .DEBOUNCE_SCANS(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .filas    (filas),
    .columnas (columnas),
    .teclas   (teclas),
    .codigo   (codigo),
    .valido   (valido)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad matrix: a held pad on the strobed row pulls its column low.
  always_comb begin
    columnas = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!filas[3-r]) begin
        for (int c = 0; c < 4; c++) begin
          if (pads[4*r+c]) columnas[c] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every valido must match the next expected code.
  always @(negedge clk) begin
    if (rst_n) begin
      check("filas_one_low", $countones(~filas), 1);
      if (valido && prev_valido) check("valido_back_to_back", 1, 0);
      if (valido) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valido", {28'd0, codigo}, 32'hFFFF_FFFF);
        end else begin
          check("codigo", {28'd0, codigo}, {28'd0, exp_q.pop_front()});
        end
      end
      prev_valido = valido;
    end else begin
      prev_valido = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    n_checks    = 0;
    n_fail      = 0;
    pads        = '0;
    prev_valido = 1'b0;
    last_code   = 4'd0;

    vecs[0]  = '{16'h0000, 2, 16'h0000, 1'b0, 4'd0};
    vecs[1]  = '{16'h0040, 1, 16'h0000, 1'b0, 4'd0};
    vecs[2]  = '{16'h0000, 2, 16'h0000, 1'b0, 4'd0};
    vecs[3]  = '{16'h0040, 2, 16'h0040, 1'b1, 4'd6};
    vecs[4]  = '{16'h0040, 2, 16'h0040, 1'b0, 4'd0};
    vecs[5]  = '{16'h0000, 1, 16'h0040, 1'b0, 4'd0};
    vecs[6]  = '{16'h0000, 1, 16'h0000, 1'b0, 4'd0};
    vecs[7]  = '{16'h0208, 2, 16'h0208, 1'b1, 4'd3};
    vecs[8]  = '{16'h0209, 2, 16'h0209, 1'b1, 4'd0};
    vecs[9]  = '{16'h8000, 2, 16'h8000, 1'b1, 4'd15};
    vecs[10] = '{16'h0000, 2, 16'h0000, 1'b0, 4'd0};

    // Reset values while held.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_filas", {28'd0, filas}, 32'h7);
    check("rst_teclas", {16'd0, teclas}, 32'h0);
    check("rst_codigo", {28'd0, codigo}, 32'h0);
    check("rst_valido", {31'd0, valido}, 32'h0);

    // Strobe sequence after release.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("filas_c0", {28'd0, filas}, 32'h7);
    for (int e = 1; e <= FRAME; e++) begin
      logic [3:0] ef;
      @(posedge clk);
      #1;
      ef = ~(4'b1000 >> ((e / DW) % 4));
      check($sformatf("filas_c%0d", e), {28'd0, filas}, {28'd0, ef});
    end

    // Fresh start for the table: vectors begin in cycle 1 of a frame.
    do_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      pads = v.pads;
      if (v.exp_strobe) begin
        exp_q.push_back(v.exp_code);
        last_code = v.exp_code;
      end
      repeat (FRAME * v.frames) @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_teclas", i), {16'd0, teclas}, {16'd0, v.exp_teclas});
      check($sformatf("v%0d_missed_strobes", i), exp_q.size(), 0);
      check($sformatf("v%0d_codigo_hold", i), {28'd0, codigo}, {28'd0, last_code});
      exp_q.delete();
    end

    // Accept pad 6, then reset in the middle of row 2.
    pads = 16'h0040;
    exp_q.push_back(4'd6);
    repeat (2 * FRAME) @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_teclas", {16'd0, teclas}, 32'h0040);
    check("pre_rst_strobe", exp_q.size(), 0);
    exp_q.delete();
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_filas", {28'd0, filas}, 32'h7);
    check("midrst_teclas", {16'd0, teclas}, 32'h0);
    check("midrst_codigo", {28'd0, codigo}, 32'h0);
    check("midrst_valido", {31'd0, valido}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'd6);
    @(posedge clk);
    repeat (FRAME) @(posedge clk);
    @(negedge clk);
    #1;
    check("post_rst_1frame_teclas", {16'd0, teclas}, 32'h0);
    repeat (FRAME) @(posedge clk);
    @(negedge clk);
    #1;
    check("post_rst_teclas", {16'd0, teclas}, 32'h0040);
    check("post_rst_strobe", exp_q.size(), 0);
    check("post_rst_codigo", {28'd0, codigo}, 32'h6);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
